// File: rtl/mult_digit_serial.sv
// Digit-serial unsigned multiplier/accumulator: one DIGIT x DIGIT partial product
// per clock is shifted into place and added to a 2*WIDTH-bit accumulator.
module mult_digit_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_ovf,
  output logic               busy
);

  localparam int ND = WIDTH / DIGIT;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = 2 * WIDTH;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and its data until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IW-1:0]      i_q;
  logic [IW-1:0]      j_q;
  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      last_q;
  logic               ovf_q;

  logic               accept;
  logic               deliver;
  logic               last_digit;
  logic [DIGIT-1:0]   a_dig;
  logic [DIGIT-1:0]   b_dig;
  logic [2*DIGIT-1:0] pp;
  logic [31:0]        sh;
  logic [PW:0]        pp_ext;
  logic [PW:0]        sum;

  assign accept     = (state == IDLE) && in_valid;
  assign deliver    = (state == DONE) && out_ready;
  assign last_digit = (i_q == IW'(ND - 1)) && (j_q == IW'(ND - 1));

  // Partial product of the current digit pair, aligned at DIGIT*(i+j).
  // Its top bit never exceeds 2*WIDTH-1, so the only carry into bit 2*WIDTH
  // comes from adding onto a preloaded accumulator.
  always_comb begin
    a_dig  = a_q[i_q*DIGIT +: DIGIT];
    b_dig  = b_q[j_q*DIGIT +: DIGIT];
    pp     = a_dig * b_dig;
    sh     = DIGIT * (32'(i_q) + 32'(j_q));
    pp_ext = {{(PW + 1 - 2*DIGIT){1'b0}}, pp} << sh;
    sum    = {1'b0, acc_q} + pp_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_digit) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      last_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        i_q   <= '0;
        j_q   <= '0;
        acc_q <= in_acc ? last_q : '0;
        ovf_q <= 1'b0;
      end else if (state == BUSY) begin
        acc_q <= sum[PW-1:0];
        ovf_q <= ovf_q | sum[PW];
        // j is the inner index; i advances when j wraps.
        if (j_q == IW'(ND - 1)) begin
          j_q <= '0;
          i_q <= (i_q == IW'(ND - 1)) ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
      if (deliver) last_q <= acc_q;
    end
  end

  // acc and ovf only change while BUSY, so they are stable throughout DONE.
  assign out_p   = acc_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_mult_digit_serial.sv
// Directed and random checks of mult_digit_serial at WIDTH=8, DIGIT=2.
module tb_mult_digit_serial;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int LAT   = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              in_acc;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic              out_ovf;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] model_last;
  logic [15:0] exp_q[$];

  mult_digit_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge. Optionally holds a following request
  // (na/nb/nacc) on the input during the out stall.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic acc,
                       input logic [15:0] exp_p, input logic exp_ovf, input int stall,
                       input logic hold, input logic [7:0] na, input logic [7:0] nb,
                       input logic nacc);
    int wait_n;
    int lat;
    in_a     = a;
    in_b     = b;
    in_acc   = acc;
    in_valid = 1'b1;
    wait_n   = 0;
    while (!in_ready && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) check("accept_timeout", 32'(wait_n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom_range(0, 255);
    in_b     = $urandom_range(0, 255);
    check("busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    for (int s = 0; s < stall; s++) begin
      if (hold) begin
        in_a     = na;
        in_b     = nb;
        in_acc   = nacc;
        in_valid = 1'b1;
      end
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_p", 32'(out_p), 32'(exp_p));
      check("stall_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    if (hold) begin
      in_a     = na;
      in_b     = nb;
      in_acc   = nacc;
      in_valid = 1'b1;
    end
    check("out_p", 32'(out_p), 32'(exp_p));
    check("out_ovf", 32'(out_ovf), 32'(exp_ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [16:0] full;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        racc;
    int          gap;
    int          quiet;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_acc    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic multiply, accumulate with wrap, accumulate without wrap.
    do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 16'hFC02, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 16'h000F, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_op(8'h07, 8'h09, 1'b1, 16'h004E, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Backpressure with a request held during the stall; it runs next.
    do_op(8'hA5, 8'h3C, 1'b0, 16'h26AC, 1'b0, 10, 1'b1, 8'h00, 8'hFF, 1'b0);
    do_op(8'h00, 8'hFF, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Leave a nonzero last result, then reset mid-operation.
    do_op(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_acc   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_p", 32'(out_p), 32'd0);
    check("arst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("arst_no_result", 32'(quiet), 32'd0);
    do_op(8'h02, 8'h03, 1'b1, 16'h0006, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random sweep against a full-width reference product.
    model_last = 16'h0006;
    for (int n = 0; n < 1000; n++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      racc = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      full = 17'(ra) * 17'(rb) + (racc ? 17'(model_last) : 17'd0);
      exp_q.push_back(full[15:0]);
      do_op(ra, rb, racc, exp_q.pop_front(), full[16], $urandom_range(0, 3),
            1'b0, 8'h00, 8'h00, 1'b0);
      model_last = full[15:0];
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
